// File: rtl/cs_frame_streamer_if.sv
// Upstream valid/ready sample stream feeding the CS frame streamer.
interface cs_frame_streamer_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/cs_frame_streamer.sv
// Buffers upstream samples and streams whole frames into the CS sliding-window
// averager, capturing CS results only for windows that lie fully inside a frame.
module cs_frame_streamer #(
    parameter int unsigned FRAME_LEN  = 16,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    cs_frame_streamer_if.slave        in_if,
    output logic                      cs_reset_o,
    output logic [7:0]                cs_x_o,
    input  logic [9:0]                cs_y_i,
    output logic [9:0]                y_data_o,
    output logic                      y_valid_o,
    output logic                      frame_done_o,
    output logic                      busy_o
);
    localparam int unsigned AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned KW  = $clog2(FRAME_LEN + 1);
    localparam int unsigned WIN = 9;

    typedef enum logic [1:0] {S_CLEAR, S_FILL, S_STREAM, S_WAIT} state_t;

    state_t        state_q;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [KW-1:0] k_q;
    logic          push, pop, not_full;
    logic          vis_q, vis_last_q, cap_q, cap_last_q;
    logic          cs_reset_q, busy_q, y_valid_q, frame_done_q;
    logic [7:0]    cs_x_q;
    logic [9:0]    y_data_q;

    // in_ready reflects the pre-pop occupancy, so a full FIFO refuses a push
    // even in a cycle where it also pops.
    assign not_full     = (count_q != CW'(FIFO_DEPTH));
    assign in_if.in_ready = not_full;
    assign push         = in_if.in_valid && not_full;
    assign pop          = (state_q == S_STREAM);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_if.in_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // Sample k is on cs_x in cycle t; CS registers it, so cs_y reflects it in
    // t+1. vis_q marks cycle t, cap_q marks cycle t+1 where cs_y is captured.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_CLEAR;
            k_q          <= '0;
            cs_reset_q   <= 1'b1;
            cs_x_q       <= '0;
            busy_q       <= 1'b0;
            vis_q        <= 1'b0;
            vis_last_q   <= 1'b0;
            cap_q        <= 1'b0;
            cap_last_q   <= 1'b0;
            y_data_q     <= '0;
            y_valid_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            cap_q        <= vis_q;
            cap_last_q   <= vis_last_q;
            y_valid_q    <= cap_q;
            frame_done_q <= cap_q && cap_last_q;
            if (cap_q) y_data_q <= cs_y_i;

            vis_q      <= 1'b0;
            vis_last_q <= 1'b0;
            cs_reset_q <= 1'b0;
            cs_x_q     <= '0;

            case (state_q)
                S_CLEAR: begin
                    cs_reset_q <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= S_FILL;
                end
                S_FILL: begin
                    k_q <= '0;
                    if (count_q >= CW'(FRAME_LEN)) begin
                        k_q     <= KW'(1);
                        busy_q  <= 1'b1;
                        state_q <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    cs_x_q     <= mem_q[rd_ptr_q];
                    vis_q      <= (k_q >= KW'(WIN));
                    vis_last_q <= (k_q == KW'(FRAME_LEN));
                    if (k_q == KW'(FRAME_LEN)) begin
                        k_q     <= '0;
                        state_q <= S_WAIT;
                    end else begin
                        k_q <= k_q + KW'(1);
                    end
                end
                S_WAIT: begin
                    busy_q  <= 1'b0;
                    state_q <= S_CLEAR;
                end
                default: state_q <= S_CLEAR;
            endcase
        end
    end

    assign cs_reset_o   = cs_reset_q;
    assign cs_x_o       = cs_x_q;
    assign y_data_o     = y_data_q;
    assign y_valid_o    = y_valid_q;
    assign frame_done_o = frame_done_q;
    assign busy_o       = busy_q;
endmodule

// File: tb/tb_cs_frame_streamer.sv
// Directed bench for cs_frame_streamer with a behavioural CS averager
// (9-sample window sum divided by 4) attached to each instance.
module tb_cs_frame_streamer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cs_frame_streamer_if a_if ();
    cs_frame_streamer_if b_if ();

    logic       a_cs_reset, b_cs_reset, a_y_valid, b_y_valid;
    logic       a_frame_done, b_frame_done, a_busy, b_busy;
    logic [7:0] a_cs_x, b_cs_x;
    logic [9:0] a_cs_y, b_cs_y, a_y_data, b_y_data;

    cs_frame_streamer dut_a (
        .clk(clk), .reset(reset), .in_if(a_if),
        .cs_reset_o(a_cs_reset), .cs_x_o(a_cs_x), .cs_y_i(a_cs_y),
        .y_data_o(a_y_data), .y_valid_o(a_y_valid),
        .frame_done_o(a_frame_done), .busy_o(a_busy)
    );

    cs_frame_streamer #(.FRAME_LEN(9), .FIFO_DEPTH(16)) dut_b (
        .clk(clk), .reset(reset), .in_if(b_if),
        .cs_reset_o(b_cs_reset), .cs_x_o(b_cs_x), .cs_y_i(b_cs_y),
        .y_data_o(b_y_data), .y_valid_o(b_y_valid),
        .frame_done_o(b_frame_done), .busy_o(b_busy)
    );

    // CS averager models: synchronous clear, Y = (sum of last 9 X) / 4
    logic [7:0]  wa [9];
    logic [7:0]  wb [9];
    logic [11:0] sa, sb;
    always_ff @(posedge clk) begin
        if (a_cs_reset) for (int i = 0; i < 9; i++) wa[i] <= '0;
        else begin
            wa[0] <= a_cs_x;
            for (int i = 1; i < 9; i++) wa[i] <= wa[i-1];
        end
        if (b_cs_reset) for (int i = 0; i < 9; i++) wb[i] <= '0;
        else begin
            wb[0] <= b_cs_x;
            for (int i = 1; i < 9; i++) wb[i] <= wb[i-1];
        end
    end
    always_comb begin
        sa = '0;
        sb = '0;
        for (int i = 0; i < 9; i++) begin
            sa = sa + 12'(wa[i]);
            sb = sb + 12'(wb[i]);
        end
    end
    assign a_cs_y = sa[11:2];
    assign b_cs_y = sb[11:2];

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  xs[$];
    int unsigned xc[$];
    int unsigned rc[$];
    logic [10:0] ys[$];
    logic [10:0] ysb[$];
    int unsigned busy_n = 0;
    int unsigned rdy_low = 0;

    always @(negedge clk) begin
        if (a_cs_x != 8'd0) begin xs.push_back(a_cs_x); xc.push_back(cyc); end
        if (a_cs_reset) rc.push_back(cyc);
        if (a_y_valid) ys.push_back({a_frame_done, a_y_data});
        if (b_y_valid) ysb.push_back({b_frame_done, b_y_data});
        if (a_busy) busy_n++;
        if (a_if.in_valid && !a_if.in_ready) rdy_low++;
    end

    int n_checks = 0;
    int n_fail = 0;
    int ex[$];

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        xs.delete(); xc.delete(); rc.delete(); ys.delete();
        busy_n = 0;
        rdy_low = 0;
    endtask

    task automatic push_a(input logic [7:0] v, output int unsigned at);
        int unsigned guard;
        guard = 0;
        a_if.in_data  = v;
        a_if.in_valid = 1'b1;
        while (!a_if.in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 200) check("push_timeout", int'(guard), 0);
        @(posedge clk); #1;
        at = cyc;
        a_if.in_valid = 1'b0;
    endtask

    task automatic wait_ys(input int n, input int budget);
        int b;
        b = 0;
        while (ys.size() < n && b < budget) begin
            @(posedge clk);
            b++;
        end
        repeat (8) @(posedge clk);
        #1;
        check("strobe_count", ys.size(), n);
    endtask

    task automatic check_ys(input string tag, input int off);
        for (int i = 0; i < ex.size(); i++) begin
            if (off + i < ys.size()) begin
                check({tag, "_y"}, int'(ys[off+i][9:0]), ex[i]);
                check({tag, "_done"}, int'(ys[off+i][10]), (i == ex.size() - 1) ? 1 : 0);
            end
        end
    endtask

    task automatic check_xs(input string tag, input int off, input int n,
                            input int v0, input int inc);
        for (int i = 0; i < n; i++) begin
            if (off + i < xs.size()) begin
                check({tag, "_x"}, int'(xs[off+i]), v0 + inc * i);
                if (i > 0) check({tag, "_gap"}, int'(xc[off+i] - xc[off+i-1]), 1);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned at;
        int b;
        int between;
        a_if.in_valid = 1'b0; a_if.in_data = '0;
        b_if.in_valid = 1'b0; b_if.in_data = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs_reset", int'(a_cs_reset), 1);
        check("rst_cs_x", int'(a_cs_x), 0);
        check("rst_y_data", int'(a_y_data), 0);
        check("rst_y_valid", int'(a_y_valid), 0);
        check("rst_frame_done", int'(a_frame_done), 0);
        check("rst_busy", int'(a_busy), 0);
        check("rst_in_ready", int'(a_if.in_ready), 1);
        reset = 1'b0;
        clear_logs();

        // FRAME_LEN = 9 build: nine samples of 100 -> single result 900/4
        b_if.in_data  = 8'd100;
        b_if.in_valid = 1'b1;
        repeat (9) @(posedge clk);
        #1;
        b_if.in_valid = 1'b0;
        b = 0;
        while (ysb.size() < 1 && b < 100) begin @(posedge clk); b++; end
        repeat (8) @(posedge clk);
        #1;
        check("f9_count", ysb.size(), 1);
        if (ysb.size() > 0) begin
            check("f9_y", int'(ysb[0][9:0]), 225);
            check("f9_done", int'(ysb[0][10]), 1);
        end

        // Ramp 1..16
        for (int v = 1; v <= 16; v++) push_a(8'(v), at);
        wait_ys(8, 200);
        ex = '{11, 13, 15, 18, 20, 22, 24, 27};
        check_ys("ramp", 0);
        check("ramp_xcount", xs.size(), 16);
        check_xs("ramp", 0, 16, 1, 1);
        check("ramp_busy", int'(busy_n), 17);

        // 10 samples, stall, 6 more: nothing streams before the 16th
        clear_logs();
        for (int v = 1; v <= 10; v++) push_a(8'(v), at);
        repeat (20) @(posedge clk);
        #1;
        for (int v = 11; v <= 16; v++) push_a(8'(v), at);
        check("stall_idle", xs.size(), 0);
        wait_ys(8, 200);
        check("stall_latency", (xc.size() > 0) ? int'(xc[0] - at) : -1, 2);
        check("stall_xcount", xs.size(), 16);
        check_xs("stall", 0, 16, 1, 1);
        check_ys("stall", 0);

        // Continuous 1..40 with back-pressure: two frames, 3 idle cycles apart
        clear_logs();
        for (int v = 1; v <= 40; v++) push_a(8'(v), at);
        wait_ys(16, 400);
        check("bp_ready_drop", (rdy_low > 0) ? 1 : 0, 1);
        check("bp_xcount", xs.size(), 32);
        check_xs("bp_f1", 0, 16, 1, 1);
        check_xs("bp_f2", 16, 16, 17, 1);
        if (xs.size() >= 17) begin
            check("bp_frame_gap", int'(xc[16] - xc[15]), 4);
            between = 0;
            foreach (rc[i]) if (rc[i] > xc[15] && rc[i] < xc[16]) between++;
            check("bp_cs_reset_pulses", between, 1);
            foreach (rc[i]) if (rc[i] > xc[15] && rc[i] < xc[16])
                check("bp_cs_reset_cycle", int'(rc[i] - xc[15]), 2);
        end
        ex = '{11, 13, 15, 18, 20, 22, 24, 27};
        check_ys("bp_f1", 0);
        ex = '{47, 49, 51, 54, 56, 58, 60, 63};
        check_ys("bp_f2", 8);

        // Reset mid-STREAM after sample 5, then a clean frame of 50s
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        clear_logs();
        for (int v = 0; v < 16; v++) push_a(8'd7, at);
        b = 0;
        while (xs.size() < 5 && b < 100) begin @(negedge clk); #1; b++; end
        check("mid_reach5", xs.size(), 5);
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid_y_valid", int'(a_y_valid), 0);
        check("mid_in_ready", int'(a_if.in_ready), 1);
        check("mid_cs_reset", int'(a_cs_reset), 1);
        check("mid_cs_x", int'(a_cs_x), 0);
        check("mid_busy", int'(a_busy), 0);
        reset = 1'b0;
        clear_logs();
        for (int v = 0; v < 16; v++) push_a(8'd50, at);
        wait_ys(8, 200);
        ex = '{112, 112, 112, 112, 112, 112, 112, 112};
        check_ys("post", 0);
        check("post_xcount", xs.size(), 16);
        check_xs("post", 0, 16, 50, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
